// File: rtl/mem_responder.sv
// Fixed-latency backing memory below the data cache: one read or write in flight,
// response after LATENCY cycles. Define MEM_RESP_STATS_EN to add rdCount/wrCount.
module mem_responder #(
  parameter int ADDR_SIZE = 10,
  parameter int DATA_SIZE = 32,
  parameter int LATENCY   = 5,
  parameter int DEPTH     = 2**ADDR_SIZE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdEnMem,
  input  logic [ADDR_SIZE-1:0] rdAddrMem,
  input  logic                 wrEnMem,
  input  logic [ADDR_SIZE-1:0] wrAddrMem,
  input  logic [DATA_SIZE-1:0] wrDataMem,
`ifdef MEM_RESP_STATS_EN
  output logic [15:0]          rdCount,
  output logic [15:0]          wrCount,
`endif
  output logic [DATA_SIZE-1:0] dataMem,
  output logic                 ready,
  output logic                 respValid
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RD_WAIT = 2'd1;
  localparam logic [1:0] WR_WAIT = 2'd2;
  localparam logic [1:0] RESP    = 2'd3;

  localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

  logic [1:0]           state;
  logic [7:0]           cnt;
  logic [ADDR_SIZE-1:0] addr_q;
  logic [DATA_SIZE-1:0] wdata_q;
  logic [DATA_SIZE-1:0] mem [DEPTH];

  logic rd_done, wr_done;
  assign rd_done = (state == RD_WAIT) && (cnt == 8'd0);
  assign wr_done = (state == WR_WAIT) && (cnt == 8'd0);

  assign ready     = (state == IDLE);
  assign respValid = (state == RESP);

  // Write wins when both enables are high; the read is simply dropped.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= 8'd0;
      dataMem <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (wrEnMem) begin
            addr_q  <= wrAddrMem;
            wdata_q <= wrDataMem;
            cnt     <= LAT_M1;
            state   <= WR_WAIT;
          end else if (rdEnMem) begin
            addr_q <= rdAddrMem;
            cnt    <= LAT_M1;
            state  <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (cnt != 8'd0) cnt <= cnt - 8'd1;
          else begin
            dataMem <= mem[addr_q];
            state   <= RESP;
          end
        end
        WR_WAIT: begin
          if (cnt != 8'd0) cnt <= cnt - 8'd1;
          else state <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Storage has no reset; a reset landing on the commit edge still blocks the write.
  always_ff @(posedge clk) begin
    if (rst && wr_done) mem[addr_q] <= wdata_q;
  end

`ifdef MEM_RESP_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      rdCount <= 16'd0;
      wrCount <= 16'd0;
    end else begin
      if (rd_done && rdCount != 16'hFFFF) rdCount <= rdCount + 16'd1;
      if (wr_done && wrCount != 16'hFFFF) wrCount <= wrCount + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a LATENCY=5 and a LATENCY=1 instance on one clock.
module tb_mem_responder;
  logic        clk = 1'b0;
  logic        rst;
  logic        rd_en   [2];
  logic        wr_en   [2];
  logic [9:0]  rd_addr [2];
  logic [9:0]  wr_addr [2];
  logic [31:0] wr_data [2];
  logic [31:0] data_mem[2];
  logic        ready   [2];
  logic        resp    [2];
`ifdef MEM_RESP_STATS_EN
  logic [15:0] rd_cnt  [2];
  logic [15:0] wr_cnt  [2];
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_acc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_responder #(.ADDR_SIZE(10), .DATA_SIZE(32), .LATENCY(5)) u5 (
    .clk(clk), .rst(rst),
    .rdEnMem(rd_en[0]), .rdAddrMem(rd_addr[0]),
    .wrEnMem(wr_en[0]), .wrAddrMem(wr_addr[0]), .wrDataMem(wr_data[0]),
`ifdef MEM_RESP_STATS_EN
    .rdCount(rd_cnt[0]), .wrCount(wr_cnt[0]),
`endif
    .dataMem(data_mem[0]), .ready(ready[0]), .respValid(resp[0])
  );

  mem_responder #(.ADDR_SIZE(10), .DATA_SIZE(32), .LATENCY(1)) u1 (
    .clk(clk), .rst(rst),
    .rdEnMem(rd_en[1]), .rdAddrMem(rd_addr[1]),
    .wrEnMem(wr_en[1]), .wrAddrMem(wr_addr[1]), .wrDataMem(wr_data[1]),
`ifdef MEM_RESP_STATS_EN
    .rdCount(rd_cnt[1]), .wrCount(wr_cnt[1]),
`endif
    .dataMem(data_mem[1]), .ready(ready[1]), .respValid(resp[1])
  );

  typedef struct {
    bit          wr;
    logic [9:0]  a;
    logic [31:0] d;
    logic [31:0] exp;   // expected dataMem after the response
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single request on instance s; checks acceptance, latency, data and return to idle.
  task automatic req(input int s, input bit wr, input logic [9:0] a, input logic [31:0] d,
                     input logic [31:0] exp, input string nm);
    int n;
    int lat;
    lat = (s == 0) ? 5 : 1;
    chk({nm, "_rdy_pre"}, 32'(ready[s]), 32'd1);
    wr_en[s] = wr; rd_en[s] = !wr;
    wr_addr[s] = a; rd_addr[s] = a; wr_data[s] = d;
    tick();
    last_acc = cyc;
    wr_en[s] = 1'b0; rd_en[s] = 1'b0;
    chk({nm, "_busy"}, 32'(ready[s]), 32'd0);
    n = 0;
    while (!resp[s] && n < 30) begin tick(); n++; end
    chk({nm, "_lat"}, 32'(n), 32'(lat));
    chk({nm, "_data"}, data_mem[s], exp);
    tick();
    chk({nm, "_rdy_post"}, {31'd0, ready[s]} | {30'd0, resp[s], 1'b0}, 32'd1);
  endtask

  task automatic count_pulses(input int s, input int cycles, output int p);
    p = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (resp[s]) p++;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, p, a1;
`ifdef MEM_RESP_STATS_EN
    logic [15:0] rc0, wc0;
`endif
    for (int s = 0; s < 2; s++) begin
      rd_en[s] = 0; wr_en[s] = 0; rd_addr[s] = 0; wr_addr[s] = 0; wr_data[s] = 0;
    end
    rst = 1'b0;
    tick(); tick();
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("reset_ready%0d", s), 32'(ready[s]), 32'd1);
      chk($sformatf("reset_resp%0d", s), 32'(resp[s]), 32'd0);
      chk($sformatf("reset_data%0d", s), data_mem[s], 32'd0);
`ifdef MEM_RESP_STATS_EN
      chk($sformatf("reset_cnt%0d", s), {rd_cnt[s], wr_cnt[s]}, 32'd0);
`endif
    end
    rst = 1'b1;
    tick();

    tbl[0] = '{1'b1, 10'h01F, 32'hDEADBEEF, 32'h00000000};
    tbl[1] = '{1'b0, 10'h01F, 32'h0,        32'hDEADBEEF};
    tbl[2] = '{1'b1, 10'h3FF, 32'h00000001, 32'hDEADBEEF};
    tbl[3] = '{1'b1, 10'h000, 32'hFFFFFFFF, 32'hDEADBEEF};
    tbl[4] = '{1'b0, 10'h3FF, 32'h0,        32'h00000001};
    tbl[5] = '{1'b0, 10'h000, 32'h0,        32'hFFFFFFFF};
    tbl[6] = '{1'b1, 10'h01F, 32'hCAFEF00D, 32'hFFFFFFFF};
    tbl[7] = '{1'b0, 10'h01F, 32'h0,        32'hCAFEF00D};
    for (int i = 0; i < 8; i++)
      req(0, tbl[i].wr, tbl[i].a, tbl[i].d, tbl[i].exp, $sformatf("vec%0d", i));

    // Cache-style held enable with address changing during the wait.
    req(0, 1'b1, 10'h005, 32'hAAAA0005, 32'hCAFEF00D, "pre5");
    req(0, 1'b1, 10'h006, 32'hBBBB0006, 32'hCAFEF00D, "pre6");
    rd_en[0] = 1'b1; rd_addr[0] = 10'h005;
    tick();
    rd_addr[0] = 10'h006;
    n = 0;
    while (!resp[0] && n < 30) begin tick(); n++; end
    chk("hold_lat", 32'(n), 32'd5);
    chk("hold_data", data_mem[0], 32'hAAAA0005);
    tick();
    chk("hold_idle", 32'(ready[0]), 32'd1);
    tick();
    chk("hold_reaccept", 32'(ready[0]), 32'd0);
    rd_en[0] = 1'b0;
    n = 0;
    while (!resp[0] && n < 30) begin tick(); n++; end
    chk("hold2_lat", 32'(n), 32'd5);
    chk("hold2_data", data_mem[0], 32'hBBBB0006);
    tick();

    // Simultaneous enables: the write wins, the read vanishes.
    req(0, 1'b1, 10'h020, 32'h55555555, 32'hBBBB0006, "pre20");
`ifdef MEM_RESP_STATS_EN
    rc0 = rd_cnt[0]; wc0 = wr_cnt[0];
`endif
    wr_en[0] = 1'b1; wr_addr[0] = 10'h010; wr_data[0] = 32'h12345678;
    rd_en[0] = 1'b1; rd_addr[0] = 10'h020;
    tick();
    wr_en[0] = 1'b0; rd_en[0] = 1'b0;
    count_pulses(0, 10, p);
    chk("both_pulses", 32'(p), 32'd1);
    chk("both_datamem", data_mem[0], 32'hBBBB0006);
`ifdef MEM_RESP_STATS_EN
    chk("both_wrcnt", 32'(wr_cnt[0] - wc0), 32'd1);
    chk("both_rdcnt", 32'(rd_cnt[0] - rc0), 32'd0);
`endif
    req(0, 1'b0, 10'h010, 32'h0, 32'h12345678, "both_rd10");
    req(0, 1'b0, 10'h020, 32'h0, 32'h55555555, "both_rd20");

    // Reset during the third wait cycle of a write.
    req(0, 1'b1, 10'h003, 32'h11111111, 32'h55555555, "pre3");
    wr_en[0] = 1'b1; wr_addr[0] = 10'h003; wr_data[0] = 32'hA5A5A5A5;
    tick();
    wr_en[0] = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("rstw_resp", 32'(resp[0]), 32'd0);
    chk("rstw_ready", 32'(ready[0]), 32'd1);
    chk("rstw_data", data_mem[0], 32'd0);
`ifdef MEM_RESP_STATS_EN
    chk("rstw_cnt", {rd_cnt[0], wr_cnt[0]}, 32'd0);
`endif
    count_pulses(0, 8, p);
    chk("rstw_pulses", 32'(p), 32'd0);
    req(0, 1'b0, 10'h003, 32'h0, 32'h11111111, "rstw_rd3");

    // LATENCY=1 back-to-back traffic.
    req(1, 1'b1, 10'h000, 32'd1, 32'd0, "l1_wr0");
    a1 = last_acc;
    req(1, 1'b1, 10'h001, 32'd2, 32'd0, "l1_wr1");
    chk("l1_spacing", 32'(last_acc - a1), 32'd3);
    req(1, 1'b0, 10'h000, 32'h0, 32'd1, "l1_rd0");
    req(1, 1'b0, 10'h001, 32'h0, 32'd2, "l1_rd1");

`ifdef MEM_RESP_STATS_EN
    u5.rdCount = 16'hFFFE;
    req(0, 1'b0, 10'h003, 32'h0, 32'h11111111, "sat_rd_a");
    chk("sat_a", 32'(rd_cnt[0]), 32'h0000FFFF);
    req(0, 1'b0, 10'h003, 32'h0, 32'h11111111, "sat_rd_b");
    chk("sat_b", 32'(rd_cnt[0]), 32'h0000FFFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
